// File: rtl/sar_search_16bit.sv
// sar_search_16bit
// Successive-approximation search controller. It drives the B input of an
// external combinational magnitude comparator whose A input is an unknown
// target. It uses the greater/less/equal feedback to binary-search the target.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         begin a search (sampled in IDLE only)
//   greater_than  comparator flag: target > guess
//   less_than     comparator flag: target < guess
//   equal         comparator flag: target == guess
//   guess         registered probe value to comparator B
//   busy          high while searching
//   done          one-cycle pulse when a search ends
//   found         result equals the target (valid with/after done)
//   error         comparator flags were not one-hot (valid with/after done)
//   result        recovered value, held until the next start
//   probes        comparisons used by the last/current search
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last search outcome
// SEARCH | one comparator probe per cycle, narrowing [lo, hi]
// DONE   | single-cycle done pulse, then back to IDLE
module sar_search_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             greater_than,
  input  logic             less_than,
  input  logic             equal,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       probes
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, hi, lo_nxt, hi_nxt;
  logic [WIDTH-1:0] guess_nxt, result_nxt;
  logic [4:0]       probes_nxt;
  logic             found_nxt, error_nxt;
  logic [WIDTH:0]   mid_sum;
  logic [1:0]       flag_cnt;
  logic             flags_onehot;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FIRST_GS = {1'b0, {(WIDTH-1){1'b1}}};

  assign flag_cnt     = {1'b0, greater_than} + {1'b0, less_than} + {1'b0, equal};
  assign flags_onehot = (flag_cnt == 2'd1);

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      probes <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      lo     <= lo_nxt;
      hi     <= hi_nxt;
      guess  <= guess_nxt;
      result <= result_nxt;
      probes <= probes_nxt;
      found  <= found_nxt;
      error  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    guess_nxt  = guess;
    result_nxt = result;
    probes_nxt = probes;
    found_nxt  = found;
    error_nxt  = error;
    mid_sum    = '0;

    case (state)
      IDLE: begin
        if (start) begin
          lo_nxt     = '0;
          hi_nxt     = '1;
          probes_nxt = '0;
          found_nxt  = 1'b0;
          error_nxt  = 1'b0;
          result_nxt = '0;
          guess_nxt  = FIRST_GS;
          state_nxt  = SEARCH;
        end
      end

      SEARCH: begin
        probes_nxt = probes + 5'd1;
        if (!flags_onehot) begin
          error_nxt = 1'b1;
          found_nxt = 1'b0;
          state_nxt = DONE;
        end else if (equal) begin
          result_nxt = guess;
          found_nxt  = 1'b1;
          state_nxt  = DONE;
        end else if (greater_than) begin
          // guess == hi means the target lies outside the remaining window;
          // stopping here also keeps guess+1 from wrapping past all-ones.
          if (guess == hi) begin
            found_nxt = 1'b0;
            state_nxt = DONE;
          end else begin
            lo_nxt = guess + ONE;
          end
        end else begin
          if (guess == lo) begin
            found_nxt = 1'b0;
            state_nxt = DONE;
          end else begin
            hi_nxt = guess - ONE;
          end
        end

        // Midpoint on a WIDTH+1 sum so lo+hi near all-ones cannot overflow.
        if (state_nxt == SEARCH) begin
          mid_sum   = {1'b0, lo_nxt} + {1'b0, hi_nxt};
          guess_nxt = mid_sum[WIDTH:1];
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
